// File: rtl/reg_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : reg_arb_pkg
// Brief    : Shared types and constants for the register-bus arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int c_tmo_cnt_w = 16;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_arb_if.sv
//------------------------------------------------------------------------------
// Module   : reg_arb_if
// Brief    : Requester-side and target-side register bus bundle for reg_arb.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface reg_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int c_strb_w = DATA_WIDTH / 8;

  logic                  req_valid_i [NUM_REQ];
  logic                  req_write_i [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_addr_i  [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_wdata_i [NUM_REQ];
  logic [c_strb_w-1:0]   req_wstrb_i [NUM_REQ];
  logic                  req_ready_o [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_rdata_o [NUM_REQ];
  logic                  req_error_o [NUM_REQ];

  logic                  tgt_valid_o;
  logic                  tgt_write_o;
  logic [ADDR_WIDTH-1:0] tgt_addr_o;
  logic [DATA_WIDTH-1:0] tgt_wdata_o;
  logic [c_strb_w-1:0]   tgt_wstrb_o;
  logic                  tgt_ready_i;
  logic [DATA_WIDTH-1:0] tgt_rdata_i;
  logic                  tgt_error_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output req_ready_o, req_rdata_o, req_error_o,
    output tgt_valid_o, tgt_write_o, tgt_addr_o, tgt_wdata_o, tgt_wstrb_o,
    input  tgt_ready_i, tgt_rdata_i, tgt_error_i
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  req_ready_o, req_rdata_o, req_error_o,
    input  tgt_valid_o, tgt_write_o, tgt_addr_o, tgt_wdata_o, tgt_wstrb_o,
    output tgt_ready_i, tgt_rdata_i, tgt_error_i
  );

endinterface

`default_nettype wire

// File: rtl/reg_arb_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : reg_arb_rr_pick
// Brief    : Combinational rotating-priority picker: first valid at/above i_rr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_arb_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int c_idx_w = $clog2(NUM_REQ);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    o_found = |i_valid;
    o_idx   = '0;
    w_pos   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_pos = int'(i_rr) + off;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      if (i_valid[w_pos[c_idx_w-1:0]]) begin
        o_idx = c_idx_w'(w_pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_arb.sv
//------------------------------------------------------------------------------
// Module   : reg_arb
// Brief    : Round-robin N:1 register-bus arbiter with zero-latency forwarding.
//            Optional BUSY timeout enabled by macro REG_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  reg_arb_if.slave                   bus,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       timeout_o
);

  localparam int c_idx_w  = $clog2(NUM_REQ);
  localparam int c_strb_w = DATA_WIDTH / 8;

  state_e               r_state;
  logic [c_idx_w-1:0]   rr_q;
  logic [c_idx_w-1:0]   gnt_q;

  logic [NUM_REQ-1:0]   w_valid_vec;
  logic                 w_found;
  logic [c_idx_w-1:0]   w_win_idx;
  logic [c_idx_w-1:0]   w_sel_idx;
  logic                 w_sel_valid;
  logic                 w_timeout;
  logic                 w_fwd;
  logic                 w_resp;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_valid
    assign w_valid_vec[i] = bus.req_valid_i[i];
  end

  reg_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_valid (w_valid_vec),
    .i_rr    (rr_q),
    .o_found (w_found),
    .o_idx   (w_win_idx)
  );

  always_comb begin
    w_sel_idx   = w_win_idx;
    w_sel_valid = w_found;
    if (r_state == BUSY) begin
      w_sel_idx   = gnt_q;
      w_sel_valid = w_valid_vec[gnt_q];
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  logic [c_tmo_cnt_w-1:0] r_tmo_cnt;

  // A ready target in the same cycle wins over the timeout.
  assign w_timeout = rst_ni && (r_state == BUSY) && w_valid_vec[gnt_q] &&
                     !bus.tgt_ready_i &&
                     (r_tmo_cnt == c_tmo_cnt_w'(TIMEOUT_CYCLES));
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  assign w_fwd  = rst_ni && w_sel_valid && !w_timeout;
  assign w_resp = (w_fwd && bus.tgt_ready_i) || w_timeout;

  assign bus.tgt_valid_o = w_fwd;
  assign bus.tgt_write_o = w_fwd && bus.req_write_i[w_sel_idx];
  assign bus.tgt_addr_o  = w_fwd ? bus.req_addr_i[w_sel_idx]  : {ADDR_WIDTH{1'b0}};
  assign bus.tgt_wdata_o = w_fwd ? bus.req_wdata_i[w_sel_idx] : {DATA_WIDTH{1'b0}};
  assign bus.tgt_wstrb_o = w_fwd ? bus.req_wstrb_i[w_sel_idx] : {c_strb_w{1'b0}};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
    logic w_hit;
    assign w_hit              = w_resp && (w_sel_idx == c_idx_w'(i));
    assign bus.req_ready_o[i] = w_hit;
    assign bus.req_error_o[i] = w_hit && (w_timeout || bus.tgt_error_i);
    assign bus.req_rdata_o[i] = (w_hit && !w_timeout) ? bus.tgt_rdata_i : {DATA_WIDTH{1'b0}};
  end

  assign busy_o    = (r_state == BUSY);
  assign grant_o   = (r_state == IDLE && w_found) ? w_win_idx : gnt_q;
  assign timeout_o = w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            gnt_q <= w_win_idx;
            if (bus.tgt_ready_i) begin
              rr_q <= c_idx_w'(wrap_inc(int'(w_win_idx), NUM_REQ));
            end else begin
              r_state   <= BUSY;
`ifdef REG_ARB_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end
          end
        end
        BUSY: begin
          // A withdrawn request leaves the rotation untouched.
          if (!w_valid_vec[gnt_q]) begin
            r_state <= IDLE;
          end else if (bus.tgt_ready_i || w_timeout) begin
            rr_q    <= c_idx_w'(wrap_inc(int'(gnt_q), NUM_REQ));
            r_state <= IDLE;
          end
`ifdef REG_ARB_TIMEOUT_EN
          else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_arb
// Brief    : Self-checking bench for reg_arb (2 requesters, TIMEOUT_CYCLES=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_arb;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [0:0] grant;
  logic       timeout;

  int    vectors = 0;
  int    miscompares = 0;
  int    m_rr = 0;
  resp_t sb[$];

  reg_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  reg_arb #(
    .NUM_REQ        (2),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .busy_o    (busy),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Response scoreboard: every req_ready_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    for (int i = 0; i < 2; i++) begin
      if (bus.req_ready_o[i] === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected req%0d ready=1 got, no response required", i);
        end else begin
          e = sb.pop_front();
          if (e.idx !== i || e.rdata !== bus.req_rdata_o[i] || e.err !== bus.req_error_o[i]) begin
            miscompares++;
            $display("FAIL resp got req%0d rdata=%h err=%b, required req%0d rdata=%h err=%b",
                     i, bus.req_rdata_o[i], bus.req_error_o[i], e.idx, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid_i[i] = 1'b0;
      bus.req_write_i[i] = 1'b0;
      bus.req_addr_i[i]  = '0;
      bus.req_wdata_i[i] = '0;
      bus.req_wstrb_i[i] = '0;
    end
    bus.tgt_ready_i = 1'b0;
    bus.tgt_rdata_i = '0;
    bus.tgt_error_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    bus.req_valid_i[0] = 1'b1;
    bus.tgt_ready_i    = 1'b1;
    @(negedge clk);
    vectors++; if (bus.tgt_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_tgt_valid got %b want 0", bus.tgt_valid_o); end
    vectors++; if (bus.req_ready_o[0] !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got %b want 0", bus.req_ready_o[0]); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got %b want 0", timeout); end
    step();
    clear_reqs();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got %b want 0", busy); end
    vectors++; if (grant !== 1'b0) begin miscompares++; $display("FAIL post_rst_grant got %0d want 0", grant); end
    vectors++; if (dut.rr_q !== 1'b0) begin miscompares++; $display("FAIL post_rst_rr got %0d want 0", dut.rr_q); end
    m_rr = 0;
    step();
  endtask

  task automatic test_single_write();
    bus.req_valid_i[1] = 1'b1;
    bus.req_write_i[1] = 1'b1;
    bus.req_addr_i[1]  = 32'h10;
    bus.req_wdata_i[1] = 32'hDEADBEEF;
    bus.req_wstrb_i[1] = 4'hF;
    bus.tgt_ready_i    = 1'b1;
    bus.tgt_rdata_i    = 32'h1234;
    sb.push_back('{1, 32'h1234, 1'b0});
    @(negedge clk);
    vectors++; if (bus.tgt_valid_o !== 1'b1) begin miscompares++; $display("FAIL wr_tgt_valid got %b want 1", bus.tgt_valid_o); end
    vectors++; if (bus.tgt_addr_o !== 32'h10) begin miscompares++; $display("FAIL wr_addr got %h want 00000010", bus.tgt_addr_o); end
    vectors++; if (bus.tgt_wdata_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_wdata got %h want deadbeef", bus.tgt_wdata_o); end
    vectors++; if (bus.tgt_write_o !== 1'b1 || bus.tgt_wstrb_o !== 4'hF) begin miscompares++; $display("FAIL wr_ctrl got write=%b strb=%h want 1/f", bus.tgt_write_o, bus.tgt_wstrb_o); end
    vectors++; if (grant !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_grant got grant=%0d busy=%b want 1/0", grant, busy); end
    step();
    clear_reqs();
    @(negedge clk);
    vectors++; if (dut.rr_q !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_rr got rr=%0d busy=%b want 0/0", dut.rr_q, busy); end
    m_rr = 0;
    step();
  endtask

  task automatic test_alternate();
    int exp;
    bus.req_valid_i[0] = 1'b1; bus.req_addr_i[0] = 32'h20;
    bus.req_valid_i[1] = 1'b1; bus.req_addr_i[1] = 32'h24;
    bus.tgt_ready_i    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp = m_rr;
      bus.tgt_rdata_i = 32'h100 + k;
      sb.push_back('{exp, 32'h100 + k, 1'b0});
      @(negedge clk);
      vectors++; if (grant !== 1'(exp)) begin miscompares++; $display("FAIL alt_grant[%0d] got %0d want %0d", k, grant, exp); end
      vectors++; if (bus.tgt_addr_o !== ((exp == 1) ? 32'h24 : 32'h20)) begin miscompares++; $display("FAIL alt_addr[%0d] got %h want %h", k, bus.tgt_addr_o, (exp == 1) ? 32'h24 : 32'h20); end
      m_rr = (exp + 1) % 2;
      step();
    end
    clear_reqs();
  endtask

  task automatic test_busy_hold();
    bus.req_valid_i[0] = 1'b1; bus.req_addr_i[0] = 32'h40;
    bus.req_valid_i[1] = 1'b1; bus.req_addr_i[1] = 32'h44;
    @(negedge clk);
    vectors++; if (grant !== 1'b0 || bus.tgt_valid_o !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL hold_grant got grant=%0d valid=%b busy=%b want 0/1/0", grant, bus.tgt_valid_o, busy); end
    step();
    for (int b = 0; b < 3; b++) begin
      if (b == 2) begin
        bus.tgt_ready_i = 1'b1;
        bus.tgt_rdata_i = 32'hA5A5;
        sb.push_back('{0, 32'hA5A5, 1'b0});
      end
      @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy[%0d] got %b want 1", b, busy); end
      vectors++; if (bus.tgt_addr_o !== 32'h40 || grant !== 1'b0) begin miscompares++; $display("FAIL hold_fwd[%0d] got addr=%h grant=%0d want 00000040/0", b, bus.tgt_addr_o, grant); end
      step();
    end
    bus.tgt_rdata_i = 32'h5A5A;
    sb.push_back('{1, 32'h5A5A, 1'b0});
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || grant !== 1'b1 || bus.tgt_addr_o !== 32'h44) begin miscompares++; $display("FAIL hold_next got busy=%b grant=%0d addr=%h want 0/1/00000044", busy, grant, bus.tgt_addr_o); end
    step();
    clear_reqs();
    m_rr = 0;
  endtask

  task automatic test_error();
    bus.req_valid_i[1] = 1'b1;
    bus.req_addr_i[1]  = 32'h80;
    bus.tgt_ready_i    = 1'b1;
    bus.tgt_error_i    = 1'b1;
    bus.tgt_rdata_i    = 32'h77;
    sb.push_back('{1, 32'h77, 1'b1});
    @(negedge clk);
    vectors++; if (grant !== 1'b1 || bus.tgt_write_o !== 1'b0) begin miscompares++; $display("FAIL err_grant got grant=%0d write=%b want 1/0", grant, bus.tgt_write_o); end
    step();
    clear_reqs();
    @(negedge clk);
    vectors++; if (dut.rr_q !== 1'b0 || bus.req_error_o[1] !== 1'b0) begin miscompares++; $display("FAIL err_after got rr=%0d err=%b want 0/0", dut.rr_q, bus.req_error_o[1]); end
    m_rr = 0;
    step();
  endtask

  task automatic test_drop();
    bus.req_valid_i[0] = 1'b1;
    bus.req_addr_i[0]  = 32'h90;
    @(negedge clk);
    vectors++; if (grant !== 1'b0) begin miscompares++; $display("FAIL drop_grant got %0d want 0", grant); end
    step();
    bus.req_valid_i[0] = 1'b0;
    @(negedge clk);
    vectors++; if (bus.tgt_valid_o !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL drop_cycle got valid=%b busy=%b want 0/1", bus.tgt_valid_o, busy); end
    step();
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || dut.rr_q !== 1'b0) begin miscompares++; $display("FAIL drop_idle got busy=%b rr=%0d want 0/0", busy, dut.rr_q); end
    step();
    clear_reqs();
  endtask

  task automatic test_idle_zero();
    bus.req_addr_i[0]  = 32'hFFFF;
    bus.req_wdata_i[1] = 32'hCAFE;
    bus.req_wstrb_i[0] = 4'hA;
    bus.req_write_i[1] = 1'b1;
    bus.tgt_ready_i    = 1'b1;
    @(negedge clk);
    vectors++; if (bus.tgt_valid_o !== 1'b0 || bus.tgt_write_o !== 1'b0) begin miscompares++; $display("FAIL idle_ctrl got valid=%b write=%b want 0/0", bus.tgt_valid_o, bus.tgt_write_o); end
    vectors++; if (bus.tgt_addr_o !== 32'h0 || bus.tgt_wdata_o !== 32'h0 || bus.tgt_wstrb_o !== 4'h0) begin miscompares++; $display("FAIL idle_fields got addr=%h wdata=%h strb=%h want 0", bus.tgt_addr_o, bus.tgt_wdata_o, bus.tgt_wstrb_o); end
    step();
    clear_reqs();
  endtask

  task automatic test_timeout();
    bus.req_valid_i[0] = 1'b1;
    bus.req_addr_i[0]  = 32'hA0;
    @(negedge clk);
    vectors++; if (grant !== 1'b0) begin miscompares++; $display("FAIL tmo_grant got %0d want 0", grant); end
    step();
`ifdef REG_ARB_TIMEOUT_EN
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b1 || timeout !== 1'b0 || bus.tgt_valid_o !== 1'b1) begin miscompares++; $display("FAIL tmo_wait[%0d] got busy=%b tmo=%b valid=%b want 1/0/1", b, busy, timeout, bus.tgt_valid_o); end
      step();
    end
    sb.push_back('{0, 32'h0, 1'b1});
    @(negedge clk);
    vectors++; if (timeout !== 1'b1 || bus.tgt_valid_o !== 1'b0) begin miscompares++; $display("FAIL tmo_fire got tmo=%b valid=%b want 1/0", timeout, bus.tgt_valid_o); end
    step();
    clear_reqs();
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || timeout !== 1'b0 || dut.rr_q !== 1'b1) begin miscompares++; $display("FAIL tmo_after got busy=%b tmo=%b rr=%0d want 0/0/1", busy, timeout, dut.rr_q); end
    m_rr = 1;
    step();
`else
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b1 || timeout !== 1'b0) begin miscompares++; $display("FAIL notmo_wait[%0d] got busy=%b tmo=%b want 1/0", b, busy, timeout); end
      step();
    end
    clear_reqs();
    step();
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL notmo_exit got busy=%b want 0", busy); end
    step();
`endif
  endtask

  task automatic test_reset_mid_busy();
    bus.req_valid_i[0] = 1'b1;
    bus.req_addr_i[0]  = 32'hB0;
    step();
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstb_busy got %b want 1", busy); end
    step();
    rst_n           = 1'b0;
    bus.tgt_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (bus.tgt_valid_o !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin miscompares++; $display("FAIL rstb_hold[%0d] got valid=%b busy=%b tmo=%b want 0/0/0", c, bus.tgt_valid_o, busy, timeout); end
      vectors++; if (bus.req_ready_o[0] !== 1'b0 || dut.rr_q !== 1'b0) begin miscompares++; $display("FAIL rstb_ready[%0d] got ready=%b rr=%0d want 0/0", c, bus.req_ready_o[0], dut.rr_q); end
      step();
    end
    clear_reqs();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || bus.tgt_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstb_after got busy=%b valid=%b want 0/0", busy, bus.tgt_valid_o); end
    m_rr = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_busy_hold();
    test_error();
    test_drop();
    test_idle_zero();
    test_timeout();
    test_reset_mid_busy();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d pending responses want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
